// File: rtl/counter_64_down_falling.sv
// ---------------------------------------------------------------------------
// counter_64_down_falling
//
// Loadable WIDTH-bit down-counter with a start/busy/done handshake. A
// controller loads a count. The block then decrements it once per enabled
// clock edge while running. When the count reaches zero, the block reports
// terminal count with a one-cycle done pulse. It is used to count remaining
// step pulses or delay ticks for the drawing-robot motor controller.
//
// All flops update on the FALLING edge of clk. The reset is asynchronous and
// active-low.
//
// Parameters
//   WIDTH        counter width; out spans 0 .. 2^WIDTH-1
//   AUTO_RELOAD  1 = on terminal count, reload the last loaded value and
//                keep running; 0 = return to idle
//
// Ports
//   clk       in   1      clock, falling-edge active
//   rst       in   1      asynchronous reset, active-low
//   en        in   1      decrement qualifier while running
//   load      in   1      start/restart request
//   load_val  in   WIDTH  count to load when load=1
//   abort     in   1      stop counting, return to idle, no done pulse
//   out       out  WIDTH  current count (registered)
//   busy      out  1      1 while in RUN (registered)
//   done      out  1      one-cycle terminal-count pulse (registered)
//   zero      out  1      1 when out==0 (combinational from out)
// ---------------------------------------------------------------------------
module counter_64_down_falling #(
    parameter int WIDTH       = 6,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------
    // State, count and reload registers. The block has falling-edge
    // timing and an asynchronous active-low reset.
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority order is abort > load > en.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            // Loading zero is already terminal, so done fires on the next period.
            state_d  = (load_val != CNT_ZERO) ? ST_RUN : ST_DONE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (en) begin
                        // A count of 1 (or a stray 0) lands on zero and ends the
                        // run; out therefore never wraps below zero.
                        if (count_q <= CNT_ONE) begin
                            count_d = CNT_ZERO;
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // DONE always lasts exactly one period.
                    if (AUTO_RELOAD && (reload_q != CNT_ZERO)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end else begin
                        count_d = CNT_ZERO;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // IDLE ignores en; count holds.
                    state_d = ST_IDLE;
                end
            endcase
        end

        // busy and done are decoded from the next state. Because of this,
        // the registered outputs line up with state_q and are glitch-free.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign out  = count_q;
    assign busy = busy_q;
    assign done = done_q;
    assign zero = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_counter_64_down_falling.sv
// ---------------------------------------------------------------------------
// Testbench for counter_64_down_falling. Two instances share the stimulus:
// one has AUTO_RELOAD=0 and the other has AUTO_RELOAD=1. A behavioural model
// predicts each instance's count and phase.
// ---------------------------------------------------------------------------
module tb_counter_64_down_falling;

    localparam int W    = 6;
    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int DONE = 2;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         abort;

    logic [W-1:0] out0, out1;
    logic         busy0, busy1, done0, done1, zero0, zero1;

    int test_cnt;
    int fail_cnt;

    // Behavioural model state: index 0 = no auto-reload, 1 = auto-reload.
    int m_phase [2];
    int m_count [2];
    int m_reload[2];

    counter_64_down_falling #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .abort(abort), .out(out0), .busy(busy0), .done(done0), .zero(zero0)
    );

    counter_64_down_falling #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .abort(abort), .out(out1), .busy(busy1), .done(done1), .zero(zero1)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        test_cnt++;
        if (obs != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i]  = IDLE;
            m_count[i]  = 0;
            m_reload[i] = 0;
        end
    endtask

    // One falling edge of the model. The rules are applied with plain arithmetic.
    task automatic model_edge(input bit e, input bit l, input int v, input bit a);
        for (int i = 0; i < 2; i++) begin
            if (a) begin
                m_phase[i] = IDLE;
                m_count[i] = 0;
            end else if (l) begin
                m_count[i]  = v;
                m_reload[i] = v;
                m_phase[i]  = (v == 0) ? DONE : RUN;
            end else if (m_phase[i] == RUN) begin
                if (e) begin
                    m_count[i] = m_count[i] - 1;
                    if (m_count[i] <= 0) begin
                        m_count[i] = 0;
                        m_phase[i] = DONE;
                    end
                end
            end else if (m_phase[i] == DONE) begin
                if (i == 1 && m_reload[i] != 0) begin
                    m_count[i] = m_reload[i];
                    m_phase[i] = RUN;
                end else begin
                    m_phase[i] = IDLE;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_out0"},  int'(out0),  m_count[0]);
        check_eq({tag, "_busy0"}, int'(busy0), int'(m_phase[0] == RUN));
        check_eq({tag, "_done0"}, int'(done0), int'(m_phase[0] == DONE));
        check_eq({tag, "_zero0"}, int'(zero0), int'(m_count[0] == 0));
        check_eq({tag, "_out1"},  int'(out1),  m_count[1]);
        check_eq({tag, "_busy1"}, int'(busy1), int'(m_phase[1] == RUN));
        check_eq({tag, "_done1"}, int'(done1), int'(m_phase[1] == DONE));
        check_eq({tag, "_zero1"}, int'(zero1), int'(m_count[1] == 0));
    endtask

    // The step is entered just after a rising edge. Inputs are driven there,
    // the falling edge is taken, and the outputs are checked just after the
    // next rising edge.
    task automatic step(input string tag, input bit e, input bit l, input int v, input bit a);
        en       = e;
        load     = l;
        load_val = W'(v);
        abort    = a;
        @(negedge clk);
        model_edge(e, l, v, a);
        @(posedge clk);
        #1;
        compare_all(tag);
        $display("[TB] %s en=%0b load=%0b val=%0d abort=%0b -> out0=%0d busy0=%0b done0=%0b | out1=%0d busy1=%0b done1=%0b",
                 tag, e, l, v, a, out0, busy0, done0, out1, busy1, done1);
    endtask

    initial begin
        test_cnt = 0;
        fail_cnt = 0;
        rst      = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        abort    = 1'b0;
        model_reset();

        // Check the state while reset is held.
        #1;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Test 2: load 5 with en held -> 5,4,3,2,1,0, then done, then idle.
        step("t2_load", 1'b1, 1'b1, 5, 1'b0);
        check_eq("t2_out_load", int'(out0), 5);
        for (int k = 4; k >= 0; k--) begin
            step("t2_cnt", 1'b1, 1'b0, 0, 1'b0);
            check_eq("t2_out_seq", int'(out0), k);
        end
        check_eq("t2_done", int'(done0), 1);
        step("t2_after", 1'b1, 1'b0, 0, 1'b0);
        check_eq("t2_idle_busy", int'(busy0), 0);
        check_eq("t2_idle_done", int'(done0), 0);

        // Test 3: load 3 with en pattern 1,0,0,1,1.
        step("t3_load", 1'b0, 1'b1, 3, 1'b1 & 1'b0);
        step("t3_e1", 1'b1, 1'b0, 0, 1'b0);
        step("t3_e0", 1'b0, 1'b0, 0, 1'b0);
        step("t3_e0", 1'b0, 1'b0, 0, 1'b0);
        check_eq("t3_hold", int'(out0), 2);
        step("t3_e1", 1'b1, 1'b0, 0, 1'b0);
        check_eq("t3_nodone", int'(done0), 0);
        step("t3_e1", 1'b1, 1'b0, 0, 1'b0);
        check_eq("t3_done", int'(done0), 1);
        step("t3_idle", 1'b0, 1'b1 & 1'b0, 0, 1'b0);

        // Test 4: load 0 -> immediate done pulse, busy never set.
        step("t4_load0", 1'b1, 1'b1, 0, 1'b0);
        check_eq("t4_done", int'(done0), 1);
        check_eq("t4_busy", int'(busy0), 0);
        step("t4_after", 1'b1, 1'b0, 0, 1'b0);

        // Test 5: restart mid-run, then abort beats load.
        step("t5_load", 1'b1, 1'b1, 6, 1'b0);
        step("t5_cnt", 1'b1, 1'b0, 0, 1'b0);
        step("t5_cnt", 1'b1, 1'b0, 0, 1'b0);
        check_eq("t5_at4", int'(out0), 4);
        step("t5_reload", 1'b1, 1'b1, 9, 1'b0);
        check_eq("t5_load_wins", int'(out0), 9);
        step("t5_abort", 1'b1, 1'b1, 12, 1'b1);
        check_eq("t5_abort_out", int'(out0), 0);
        check_eq("t5_abort_done", int'(done0), 0);

        // Test 6: auto-reload with load 2, then 63 with en=0 must hold.
        step("t6_load", 1'b1, 1'b1, 2, 1'b0);
        for (int k = 0; k < 6; k++)
            step("t6_run", 1'b1, 1'b0, 0, 1'b0);
        check_eq("t6_auto_out", int'(out1), 2);
        step("t6_load63", 1'b0, 1'b1, 63, 1'b0);
        for (int k = 0; k < 3; k++)
            step("t6_hold", 1'b0, 1'b0, 0, 1'b0);
        check_eq("t6_hold63", int'(out1), 63);
        step("t6_abort", 1'b0, 1'b0, 0, 1'b1);

        // Test 1: asynchronous reset mid-run with no clock edge.
        step("t1_load", 1'b0, 1'b1, 37, 1'b0);
        step("t1_hold", 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("t1_async");
        $display("[TB] t1_async rst=0 -> out0=%0d busy0=%0b done0=%0b zero0=%0b", out0, busy0, done0, zero0);
        #1;
        rst = 1'b1;

        // Randomised traffic; small load values are favoured so runs complete.
        for (int n = 0; n < 400; n++) begin
            bit e, l, a;
            int v;
            e = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 63));
            step("rand", e, l, v, a);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        fail_cnt++;
        $display("FAIL timeout: got no finish, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
